demux_deser16: RTL and testbench

Serial-to-parallel 1-to-16 demultiplexing collector, the receive-side counterpart of `mux16x1`. A serial bit stream is steered bit-by-bit into slot `S` of a 16-bit shadow register, with `S` advancing 0→15. A completed word is presented on `Y` with a valid/ready handshake. The block sits after any path that serialises a 16-bit word LSB-first by sweeping a 16:1 mux select from 0 to 15, and reconstructs that word.

---
 rtl/demux_deser16_if.sv | 23 ++
 rtl/demux_deser16.sv | 86 ++++++++
 tb/tb_demux_deser16.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_deser16_if.sv
// Bundles the serial-input and word-output handshakes of demux_deser16.
// The slave modport is the collector side; the master modport drives bits and consumes words.
interface demux_deser16_if;
    logic        D;
    logic        D_valid;
    logic        D_ready;
    logic        sync;
    logic [3:0]  S;
    logic [15:0] Y;
    logic        Y_valid;
    logic        Y_ready;
    logic        frame_err;

    modport master (
        output D, D_valid, sync, Y_ready,
        input  D_ready, S, Y, Y_valid, frame_err
    );

    modport slave (
        input  D, D_valid, sync, Y_ready,
        output D_ready, S, Y, Y_valid, frame_err
    );
endinterface

// File: rtl/demux_deser16.sv
// Serial-to-parallel 1:16 collector: LSB-first bits are steered into slot S of a shadow
// register and each completed word is offered on Y with a valid/ready handshake.
module demux_deser16 (
    input  logic            clk,
    input  logic            rst,
    demux_deser16_if.slave  bus
);

    typedef enum logic [1:0] {EMPTY, COLLECT, FULL} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  slot;
    logic [14:0] shadow;
    logic [15:0] word;
    logic        err;

    // ---- state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (bus.D_valid) state_next = COLLECT;
            end
            COLLECT: begin
                if (bus.sync) begin
                    state_next = bus.D_valid ? COLLECT : EMPTY;
                end else if (bus.D_valid && slot == 4'd15) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (bus.Y_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // ---- slot index, shadow collection, word and abort flag ----
    // The bit arriving at slot 15 goes straight into Y, so the shadow only needs 15 slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot   <= 4'd0;
            shadow <= 15'd0;
            word   <= 16'd0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state != FULL) begin
                if (bus.sync) begin
                    // A coincident bit starts the new frame as bit 0.
                    err <= (state == COLLECT) && (slot != 4'd0);
                    if (bus.D_valid) begin
                        shadow <= {14'd0, bus.D};
                        slot   <= 4'd1;
                    end else begin
                        shadow <= 15'd0;
                        slot   <= 4'd0;
                    end
                end else if (bus.D_valid) begin
                    if (slot == 4'd15) begin
                        word <= {bus.D, shadow};
                    end else begin
                        shadow[slot] <= bus.D;
                    end
                    slot <= slot + 4'd1;
                end
            end
        end
    end

    assign bus.D_ready   = (state != FULL);
    assign bus.Y_valid   = (state == FULL);
    assign bus.S         = slot;
    assign bus.Y         = word;
    assign bus.frame_err = err;

endmodule

// File: tb/tb_demux_deser16.sv
// Directed bench for demux_deser16: reset, word collection, hold/handshake, sync aborts,
// sync while full, back-to-back words and reset mid-frame.
module tb_demux_deser16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    demux_deser16_if bus ();

    demux_deser16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            bus.D       = w[i];
            bus.D_valid = 1'b1;
            step();
        end
        bus.D_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.D       = 1'b0;
        bus.D_valid = 1'b0;
        bus.sync    = 1'b0;
        bus.Y_ready = 1'b0;
        rst         = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.S !== 4'd0) begin
            miscompares++; $display("FAIL reset_S got %0d want 0", bus.S);
        end
        vectors++;
        if (bus.Y !== 16'h0000) begin
            miscompares++; $display("FAIL reset_Y got %h want 0000", bus.Y);
        end
        vectors++;
        if (bus.Y_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_Y_valid got %b want 0", bus.Y_valid);
        end
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (bus.D_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_D_ready got %b want 1", bus.D_ready);
        end
    endtask

    task automatic test_collect;
        logic [15:0] w;
        w = 16'b1001101001101001;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (bus.S !== 4'(i)) begin
                miscompares++; $display("FAIL collect_S got %0d want %0d", bus.S, i);
            end
            vectors++;
            if (bus.D_ready !== 1'b1) begin
                miscompares++; $display("FAIL collect_D_ready got %b want 1 at bit %0d", bus.D_ready, i);
            end
            bus.D       = w[i];
            bus.D_valid = 1'b1;
            step();
        end
        bus.D_valid = 1'b0;
        vectors++;
        if (bus.Y !== 16'h9A69) begin
            miscompares++; $display("FAIL collect_Y got %h want 9a69", bus.Y);
        end
        vectors++;
        if (bus.Y_valid !== 1'b1) begin
            miscompares++; $display("FAIL collect_Y_valid got %b want 1", bus.Y_valid);
        end
        vectors++;
        if (bus.S !== 4'd0) begin
            miscompares++; $display("FAIL collect_S_wrap got %0d want 0", bus.S);
        end
        vectors++;
        if (bus.D_ready !== 1'b0) begin
            miscompares++; $display("FAIL collect_D_ready_full got %b want 0", bus.D_ready);
        end
    endtask

    task automatic test_hold_handshake;
        // Offered bits while full must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.D       = 1'b1;
            bus.D_valid = 1'b1;
            step();
            vectors++;
            if (bus.Y_valid !== 1'b1 || bus.Y !== 16'h9A69 || bus.S !== 4'd0) begin
                miscompares++;
                $display("FAIL hold got Y_valid=%b Y=%h S=%0d want 1 9a69 0", bus.Y_valid, bus.Y, bus.S);
            end
        end
        bus.D_valid = 1'b0;
        bus.Y_ready = 1'b1;
        step();
        bus.Y_ready = 1'b0;
        vectors++;
        if (bus.Y_valid !== 1'b0) begin
            miscompares++; $display("FAIL handshake_Y_valid got %b want 0", bus.Y_valid);
        end
        vectors++;
        if (bus.Y !== 16'h9A69) begin
            miscompares++; $display("FAIL handshake_Y_kept got %h want 9a69", bus.Y);
        end
        vectors++;
        if (bus.D_ready !== 1'b1) begin
            miscompares++; $display("FAIL handshake_D_ready got %b want 1", bus.D_ready);
        end
        bus.D       = 1'b1;
        bus.D_valid = 1'b1;
        step();
        bus.D_valid = 1'b0;
        vectors++;
        if (bus.S !== 4'd1) begin
            miscompares++; $display("FAIL next_bit_S got %0d want 1", bus.S);
        end
    endtask

    task automatic test_sync_abort;
        logic [15:0] pat;
        pat = 16'hFFFE;
        // One bit is already held; six more make seven.
        for (int i = 0; i < 6; i++) begin
            bus.D       = i[0];
            bus.D_valid = 1'b1;
            step();
        end
        vectors++;
        if (bus.S !== 4'd7) begin
            miscompares++; $display("FAIL pre_sync_S got %0d want 7", bus.S);
        end
        bus.sync    = 1'b1;
        bus.D       = 1'b1;
        bus.D_valid = 1'b1;
        step();
        bus.sync = 1'b0;
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++; $display("FAIL sync_frame_err got %b want 1", bus.frame_err);
        end
        vectors++;
        if (bus.S !== 4'd1) begin
            miscompares++; $display("FAIL sync_S got %0d want 1", bus.S);
        end
        for (int i = 1; i < 16; i++) begin
            bus.D       = pat[i];
            bus.D_valid = 1'b1;
            step();
            if (i == 1) begin
                vectors++;
                if (bus.frame_err !== 1'b0) begin
                    miscompares++; $display("FAIL frame_err_width got %b want 0", bus.frame_err);
                end
            end
        end
        bus.D_valid = 1'b0;
        vectors++;
        if (bus.Y !== 16'hFFFF || bus.Y_valid !== 1'b1) begin
            miscompares++; $display("FAIL sync_word got Y=%h Y_valid=%b want ffff 1", bus.Y, bus.Y_valid);
        end
        bus.Y_ready = 1'b1;
        step();
        bus.Y_ready = 1'b0;
    endtask

    task automatic test_sync_full;
        send_word(16'h9A69);
        bus.sync    = 1'b1;
        bus.D       = 1'b0;
        bus.D_valid = 1'b1;
        step();
        bus.sync    = 1'b0;
        bus.D_valid = 1'b0;
        vectors++;
        if (bus.Y !== 16'h9A69 || bus.Y_valid !== 1'b1 || bus.S !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_full got Y=%h Y_valid=%b S=%0d want 9a69 1 0", bus.Y, bus.Y_valid, bus.S);
        end
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL sync_full_frame_err got %b want 0", bus.frame_err);
        end
        step();
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL sync_full_frame_err_late got %b want 0", bus.frame_err);
        end
        bus.Y_ready = 1'b1;
        step();
        bus.Y_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        exp_valid;
        a = 16'h9A69;
        b = 16'h0001;
        c = 16'hFFFF;
        bus.Y_ready = 1'b1;
        // Edges 1-16 carry word a, 17 is the handshake bubble, 18-33 carry word b.
        for (int e = 1; e <= 34; e++) begin
            bus.D_valid = (e <= 33);
            if (e <= 16)      bus.D = a[e-1];
            else if (e >= 18 && e <= 33) bus.D = b[e-18];
            else              bus.D = 1'b1;
            step();
            exp_valid = (e == 16) || (e == 33);
            vectors++;
            if (bus.Y_valid !== exp_valid) begin
                miscompares++; $display("FAIL b2b_Y_valid edge %0d got %b want %b", e, bus.Y_valid, exp_valid);
            end
            if (e == 16) begin
                vectors++;
                if (bus.Y !== 16'h9A69) begin
                    miscompares++; $display("FAIL b2b_Y_first got %h want 9a69", bus.Y);
                end
            end
            if (e == 33) begin
                vectors++;
                if (bus.Y !== 16'h0001) begin
                    miscompares++; $display("FAIL b2b_Y_second got %h want 0001", bus.Y);
                end
            end
        end
        bus.Y_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.D       = c[i];
            bus.D_valid = 1'b1;
            step();
        end
        vectors++;
        if (bus.S !== 4'd9) begin
            miscompares++; $display("FAIL third_S got %0d want 9", bus.S);
        end
        bus.D = c[9];
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.S !== 4'd0 || bus.Y !== 16'h0000 || bus.Y_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_rst got S=%0d Y=%h Y_valid=%b frame_err=%b want 0 0000 0 0",
                     bus.S, bus.Y, bus.Y_valid, bus.frame_err);
        end
        step();
        rst         = 1'b0;
        bus.D_valid = 1'b0;
        step();
        vectors++;
        if (bus.frame_err !== 1'b0 || bus.Y_valid !== 1'b0 || bus.D_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst got frame_err=%b Y_valid=%b D_ready=%b want 0 0 1",
                     bus.frame_err, bus.Y_valid, bus.D_ready);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_collect();
        test_hold_handshake();
        test_sync_abort();
        test_sync_full();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
